// File: rtl/memory_reader_pkg.sv
// Shared constants, FSM state type and burst-length clamp for memory_reader.
package mem_pkg;

   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 2;
   localparam int DEPTH     = 4;
   localparam int MAX_BURST = 4;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      PRESENT,
      DONE
   } state_t;

   // Requests above MAX_BURST are trimmed rather than rejected.
   function automatic logic [2:0] clamp_count(input logic [2:0] c);
      return (c > 3'(MAX_BURST)) ? 3'(MAX_BURST) : c;
   endfunction

endpackage

// File: rtl/memory_reader_if.sv
// Command, memory-port and output-stream signals of memory_reader.
// Carries a checksum output when MEM_READER_CHECKSUM_EN is defined.
interface memory_reader_if;
   import mem_pkg::*;

   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [2:0]        count;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              done;
`ifdef MEM_READER_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;

   modport master (
      input  start, start_addr, count, mem_data, out_ready,
      output mem_addr, out_data, out_valid, busy, done, checksum
   );

   modport slave (
      output start, start_addr, count, mem_data, out_ready,
      input  mem_addr, out_data, out_valid, busy, done, checksum
   );
`else
   modport master (
      input  start, start_addr, count, mem_data, out_ready,
      output mem_addr, out_data, out_valid, busy, done
   );

   modport slave (
      output start, start_addr, count, mem_data, out_ready,
      input  mem_addr, out_data, out_valid, busy, done
   );
`endif

endinterface

// File: rtl/memory_reader_wrap_counter.sv
// Loadable address counter that wraps modulo DEPTH; holds the current read address.
module wrap_counter
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] load_val,
   output logic [ADDR_W-1:0] value
);

   // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (inc) begin
         value <= (value == ADDR_W'(DEPTH - 1)) ? '0 : value + 1'b1;
      end
   end

endmodule

// File: rtl/memory_reader.sv
// Read-side burst sequencer: walks consecutive array addresses and streams bytes out.
// Optional checksum output is enabled with MEM_READER_CHECKSUM_EN.
module memory_reader
   import mem_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   memory_reader_if.master bus
);

   state_t            state;
   logic [2:0]        remaining;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] out_data_q;
   logic              out_valid_q;
   logic              busy_q;
   logic              done_q;
   logic              accept;
   logic              handshake;

   assign accept    = (state == IDLE) && bus.start;
   assign handshake = (state == PRESENT) && out_valid_q && bus.out_ready;

   // The address advances only between bytes, never after the last one.
   wrap_counter u_addr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .inc      (handshake && (remaining != 3'd1)),
      .load_val (bus.start_addr),
      .value    (cur_addr)
   );

   assign bus.mem_addr  = cur_addr;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         remaining   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  remaining <= clamp_count(bus.count);
                  busy_q    <= 1'b1;
                  if (clamp_count(bus.count) == 3'd0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= FETCH;
                  end
               end
            end
            FETCH: begin
               out_data_q  <= bus.mem_data;
               out_valid_q <= 1'b1;
               state       <= PRESENT;
            end
            PRESENT: begin
               if (handshake) begin
                  out_valid_q <= 1'b0;
                  remaining   <= remaining - 3'd1;
                  if (remaining == 3'd1) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= FETCH;
                  end
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_READER_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q;

   always_ff @(posedge clk) begin
      if (!rst_n || accept) begin
         checksum_q <= '0;
      end else if (handshake) begin
         checksum_q <= checksum_q ^ out_data_q;
      end
   end

   assign bus.checksum = checksum_q;
`endif

endmodule
